reg_file: RTL and testbench

REG_FILE -- requirements
Module: reg_file

---
 rtl/regfile_pkg.sv | 18 +
 rtl/reg_clr_fsm.sv | 64 ++++++
 rtl/reg_file.sv | 75 +++++++
 tb/tb_reg_file.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared widths, register count and clear-sequencer state encoding.
`default_nettype none

package regfile_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int NREG       = 2 ** DEF_ADDR_W;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_DONE  = 2'd2
    } clr_state_e;

endpackage : regfile_pkg

`default_nettype wire

// File: rtl/reg_clr_fsm.sv
// reg_clr_fsm: bulk-clear sequencer; walks registers 1..2**ADDR_W-1 writing zero, then pulses done.
`default_nettype none

module reg_clr_fsm
    import regfile_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_req_i,
    output logic              clr_busy_o,
    output logic              clr_done_o,
    output logic              clr_we_o,
    output logic [ADDR_W-1:0] clr_addr_o
);

    localparam logic [ADDR_W-1:0] C_LAST = {ADDR_W{1'b1}};

    clr_state_e        state_q, state_d;
    logic [ADDR_W-1:0] ptr_q,   ptr_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (clr_req_i) begin
                    state_d = ST_CLEAR;
                    ptr_d   = ADDR_W'(1);
                end
            end
            ST_CLEAR: begin
                // Explicit exit at the last register keeps the pointer from wrapping.
                if (ptr_q == C_LAST) begin
                    state_d = ST_DONE;
                    ptr_d   = '0;
                end else begin
                    ptr_d   = ptr_q + ADDR_W'(1);
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign clr_busy_o = (state_q != ST_IDLE);
    assign clr_done_o = (state_q == ST_DONE);
    assign clr_we_o   = (state_q == ST_CLEAR);
    assign clr_addr_o = ptr_q;

endmodule : reg_clr_fsm

`default_nettype wire

// File: rtl/reg_file.sv
// reg_file: 2R1W register file with hard-wired zero register, write bypass, debug port and bulk clear.
`default_nettype none

module reg_file
    import regfile_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] wd,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    input  logic              clr_req,
    output logic              clr_busy,
    output logic              clr_done
);

    localparam int C_NREG = 2 ** ADDR_W;

    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic              wr_ok;
    logic [DATA_W-1:0] regs [C_NREG];

    reg_clr_fsm #(
        .ADDR_W (ADDR_W)
    ) u_clr_fsm (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_req_i  (clr_req),
        .clr_busy_o (clr_busy),
        .clr_done_o (clr_done),
        .clr_we_o   (clr_we),
        .clr_addr_o (clr_addr)
    );

    // Normal writes only land while the sequencer is idle; register 0 is never stored.
    assign wr_ok = we && (wa != '0) && !clr_busy;

    genvar i;
    generate
        for (i = 0; i < C_NREG; i++) begin : g_reg
            if (i == 0) begin : g_zero
                assign regs[i] = '0;
            end else begin : g_store
                logic [DATA_W-1:0] data_q;
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        data_q <= '0;
                    end else if (clr_we && (clr_addr == ADDR_W'(i))) begin
                        data_q <= '0;
                    end else if (wr_ok && (wa == ADDR_W'(i))) begin
                        data_q <= wd;
                    end
                end
                assign regs[i] = data_q;
            end
        end
    endgenerate

    assign rd1      = (wr_ok && (wa == ra1)) ? wd : regs[ra1];
    assign rd2      = (wr_ok && (wa == ra2)) ? wd : regs[ra2];
    assign dbg_data = regs[dbg_addr];

endmodule : reg_file

`default_nettype wire

// File: tb/tb_reg_file.sv
// tb_reg_file: directed self-checking bench for reg_file.
`default_nettype none

module tb_reg_file;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra1, ra2, dbg_addr;
    logic [31:0] rd1, rd2, dbg_data;
    logic        clr_req, clr_busy, clr_done;

    int n_cmp = 0;
    int n_err = 0;

    reg_file dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (we),
        .wa       (wa),
        .wd       (wd),
        .ra1      (ra1),
        .ra2      (ra2),
        .rd1      (rd1),
        .rd2      (rd2),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data),
        .clr_req  (clr_req),
        .clr_busy (clr_busy),
        .clr_done (clr_done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
        we = 1'b1; wa = a; wd = d;
        tick();
        we = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (clr_busy && k < 60) begin
            tick();
            k++;
        end
        n_cmp++;
        if (clr_busy !== 1'b0) begin
            n_err++;
            $display("FAIL wait_idle: clr_busy=%b after %0d cycles, required 0", clr_busy, k);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; we = 0; wa = 0; wd = 0; ra1 = 0; ra2 = 0; dbg_addr = 0; clr_req = 0;
        tick(); tick();
        n_cmp++;
        if (clr_busy !== 1'b0 || clr_done !== 1'b0) begin
            n_err++;
            $display("FAIL reset_flags: busy=%b done=%b, required 0 0", clr_busy, clr_done);
        end
        dbg_addr = 5'd9; ra1 = 5'd31; #1;
        n_cmp++;
        if (dbg_data !== 32'h0 || rd1 !== 32'h0) begin
            n_err++;
            $display("FAIL reset_regs: dbg=%h rd1=%h, required 0 0", dbg_data, rd1);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_write_read();
        we = 1; wa = 5'd5; wd = 32'hDEADBEEF; ra2 = 5'd5; dbg_addr = 5'd5; #1;
        n_cmp++;
        if (rd2 !== 32'hDEADBEEF) begin
            n_err++;
            $display("FAIL bypass_rd2: got %h, required deadbeef", rd2);
        end
        n_cmp++;
        if (dbg_data !== 32'h0) begin
            n_err++;
            $display("FAIL dbg_no_bypass: got %h, required 0", dbg_data);
        end
        tick();
        we = 0; ra1 = 5'd5; #1;
        n_cmp++;
        if (rd1 !== 32'hDEADBEEF || dbg_data !== 32'hDEADBEEF) begin
            n_err++;
            $display("FAIL write_read: rd1=%h dbg=%h, required deadbeef", rd1, dbg_data);
        end
        write_reg(5'd12, 32'h0000_1212);
        ra1 = 5'd12; ra2 = 5'd5; #1;
        n_cmp++;
        if (rd1 !== 32'h0000_1212 || rd2 !== 32'hDEADBEEF) begin
            n_err++;
            $display("FAIL two_ports: rd1=%h rd2=%h, required 00001212 deadbeef", rd1, rd2);
        end
    endtask

    task automatic test_reg0();
        we = 1; wa = 5'd0; wd = 32'hFFFFFFFF; ra1 = 5'd0; dbg_addr = 5'd0; #1;
        n_cmp++;
        if (rd1 !== 32'h0) begin
            n_err++;
            $display("FAIL reg0_during: rd1=%h, required 0", rd1);
        end
        tick();
        we = 0; #1;
        n_cmp++;
        if (rd1 !== 32'h0 || dbg_data !== 32'h0) begin
            n_err++;
            $display("FAIL reg0_after: rd1=%h dbg=%h, required 0 0", rd1, dbg_data);
        end
    endtask

    task automatic test_clear();
        int busy_cnt, done_cnt, done_at, bad;
        for (int r = 1; r < 32; r++) write_reg(5'(r), 32'(r));
        dbg_addr = 5'd17; #1;
        n_cmp++;
        if (dbg_data !== 32'd17) begin
            n_err++;
            $display("FAIL fill: r17=%h, required 11", dbg_data);
        end
        clr_req = 1; tick(); clr_req = 0;
        busy_cnt = 0; done_cnt = 0; done_at = 0;
        for (int k = 1; k <= 40; k++) begin
            if (clr_busy) busy_cnt++;
            if (clr_done) begin done_cnt++; done_at = k; end
            tick();
        end
        n_cmp++;
        if (busy_cnt != 32) begin
            n_err++;
            $display("FAIL clear_busy_len: got %0d cycles, required 32", busy_cnt);
        end
        n_cmp++;
        if (done_cnt != 1 || done_at != 32) begin
            n_err++;
            $display("FAIL clear_done: %0d pulses at cycle %0d, required 1 at 32", done_cnt, done_at);
        end
        bad = 0;
        for (int r = 0; r < 32; r++) begin
            dbg_addr = 5'(r); #1;
            if (dbg_data !== 32'h0) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL clear_contents: %0d nonzero registers, required 0", bad);
        end
    endtask

    task automatic test_write_during_clear();
        write_reg(5'd31, 32'h0000_AAAA);
        clr_req = 1; tick(); clr_req = 0;
        repeat (9) tick();
        we = 1; wa = 5'd31; wd = 32'h12345678; ra1 = 5'd31; #1;
        n_cmp++;
        if (rd1 !== 32'h0000_AAAA) begin
            n_err++;
            $display("FAIL busy_no_bypass: rd1=%h, required 0000aaaa", rd1);
        end
        tick();
        we = 0; #1;
        n_cmp++;
        if (rd1 !== 32'h0000_AAAA) begin
            n_err++;
            $display("FAIL busy_write_ignored: rd1=%h, required 0000aaaa", rd1);
        end
        clr_req = 1; tick(); clr_req = 0;
        wait_idle();
        dbg_addr = 5'd31; #1;
        n_cmp++;
        if (dbg_data !== 32'h0) begin
            n_err++;
            $display("FAIL busy_r31_cleared: got %h, required 0", dbg_data);
        end
    endtask

    task automatic test_simultaneous();
        int early_bad;
        we = 1; wa = 5'd7; wd = 32'h55; clr_req = 1;
        tick();
        we = 0; clr_req = 0; dbg_addr = 5'd7;
        early_bad = 0;
        for (int k = 1; k <= 7; k++) begin
            #1;
            if (dbg_data !== 32'h55) early_bad++;
            tick();
        end
        n_cmp++;
        if (early_bad != 0) begin
            n_err++;
            $display("FAIL simul_hold: %0d of 7 cycles not 00000055", early_bad);
        end
        #1;
        n_cmp++;
        if (dbg_data !== 32'h0) begin
            n_err++;
            $display("FAIL simul_cleared: r7=%h, required 0", dbg_data);
        end
        wait_idle();
    endtask

    task automatic test_reset_mid_clear();
        int dones;
        write_reg(5'd3, 32'h33);
        write_reg(5'd20, 32'h20);
        clr_req = 1; tick(); clr_req = 0;
        repeat (14) tick();
        dbg_addr = 5'd20; #1;
        n_cmp++;
        if (dbg_data !== 32'h20 || clr_busy !== 1'b1) begin
            n_err++;
            $display("FAIL pre_reset: r20=%h busy=%b, required 00000020 1", dbg_data, clr_busy);
        end
        rst_n = 1'b0; #1;
        n_cmp++;
        if (clr_busy !== 1'b0 || clr_done !== 1'b0 || dbg_data !== 32'h0) begin
            n_err++;
            $display("FAIL async_reset: busy=%b done=%b r20=%h, required 0 0 0", clr_busy, clr_done, dbg_data);
        end
        tick();
        rst_n = 1'b1; we = 1; wa = 5'd3; wd = 32'h77;
        tick();
        we = 0; dbg_addr = 5'd3; #1;
        n_cmp++;
        if (dbg_data !== 32'h77) begin
            n_err++;
            $display("FAIL write_after_reset: r3=%h, required 00000077", dbg_data);
        end
        dones = 0;
        for (int k = 0; k < 35; k++) begin
            if (clr_done || clr_busy) dones++;
            tick();
        end
        n_cmp++;
        if (dones != 0) begin
            n_err++;
            $display("FAIL no_done_after_abort: %0d busy/done cycles, required 0", dones);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_reg0();
        test_clear();
        test_write_during_clear();
        test_simultaneous();
        test_reset_mid_clear();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_reg_file

`default_nettype wire
